// File: rtl/cpu_bus_pkg.sv
// ----------------------------------------------------------------------------
// cpu_bus_pkg
// Shared definitions for the CPU memory-bus arbiter slice:
//   - default address/data widths
//   - arbiter state encodings
//   - requester identifiers
// No ports (package).
// ----------------------------------------------------------------------------
package cpu_bus_pkg;

    localparam int CPU_BUS_AW = 32;
    localparam int CPU_BUS_DW = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

endpackage

// File: rtl/cpu_mem_bus_arb_perf.sv
// ----------------------------------------------------------------------------
// cpu_mem_bus_arb_perf
// Grant and contention counters for the memory-bus arbiter. Only instantiated
// when CPU_ARB_PERF_EN is defined. Counters wrap modulo 2^PERF_WIDTH.
// Ports:
//   clock, reset       clock and asynchronous active-low reset
//   igrant, dgrant     one-cycle pulses when an ibus / dbus grant is issued
//   conflict           both requesters pending this cycle
//   perf_igrant        ibus grant count
//   perf_dgrant        dbus grant count
//   perf_conflict      cycles with both requests pending
// ----------------------------------------------------------------------------
module cpu_mem_bus_arb_perf
    import cpu_bus_pkg::*;
#(
    parameter int PERF_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  igrant,
    input  logic                  dgrant,
    input  logic                  conflict,
    output logic [PERF_WIDTH-1:0] perf_igrant,
    output logic [PERF_WIDTH-1:0] perf_dgrant,
    output logic [PERF_WIDTH-1:0] perf_conflict
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_igrant   <= '0;
            perf_dgrant   <= '0;
            perf_conflict <= '0;
        end else begin
            if (igrant) begin
                perf_igrant <= perf_igrant + PERF_WIDTH'(1);
            end
            if (dgrant) begin
                perf_dgrant <= perf_dgrant + PERF_WIDTH'(1);
            end
            if (conflict) begin
                perf_conflict <= perf_conflict + PERF_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// cpu_mem_bus_arbiter
// Shares one external memory port between the instruction-fetch bus (ibus)
// and the data bus (dbus). dbus has priority; a starvation counter forces an
// ibus grant after STARVE_LIMIT consecutive dbus grants taken while ibus was
// waiting. Address/strobes of the granted transaction are registered onto
// the memory port; read data, stall and error are routed back
// combinationally to the granted requester.
//
// Optional feature: define CPU_ARB_PERF_EN to add perf_igrant, perf_dgrant
// and perf_conflict counter outputs (PERF_WIDTH bits each).
//
// Ports:
//   clock, reset                 clock, asynchronous active-low reset
//   ibus_address/read            fetch request in
//   ibus_data/stall/error        fetch response out
//   dbus_address/read/write      data request in (write wins over read)
//   dbus_wdata/byteenable        store data and lanes
//   dbus_data/stall/error        data response out
//   mem_address/read/write       registered memory-port request
//   mem_wdata/byteenable         registered store data; lanes all ones on reads
//   mem_rdata/stall/error        memory response in
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction on the memory port; arbitrate pending requests
// GRANT_I | ibus transaction on the memory port, waiting for mem_stall=0
// GRANT_D | dbus transaction on the memory port, waiting for mem_stall=0
// ----------------------------------------------------------------------------
module cpu_mem_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_WIDTH   = CPU_BUS_AW,
    parameter int DATA_WIDTH   = CPU_BUS_DW,
    parameter int STARVE_LIMIT = 4
`ifdef CPU_ARB_PERF_EN
    ,
    parameter int PERF_WIDTH   = 32
`endif
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic [ADDR_WIDTH-1:0]   ibus_address,
    input  logic                    ibus_read,
    output logic [DATA_WIDTH-1:0]   ibus_data,
    output logic                    ibus_stall,
    output logic                    ibus_error,

    input  logic [ADDR_WIDTH-1:0]   dbus_address,
    input  logic                    dbus_read,
    input  logic                    dbus_write,
    input  logic [DATA_WIDTH-1:0]   dbus_wdata,
    input  logic [DATA_WIDTH/8-1:0] dbus_byteenable,
    output logic [DATA_WIDTH-1:0]   dbus_data,
    output logic                    dbus_stall,
    output logic                    dbus_error,

    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_byteenable,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_stall,
    input  logic                    mem_error
`ifdef CPU_ARB_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0]   perf_igrant,
    output logic [PERF_WIDTH-1:0]   perf_dgrant,
    output logic [PERF_WIDTH-1:0]   perf_conflict
`endif
);

    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t      state, state_nxt;
    logic [SW-1:0]   starve_cnt;
    logic            dbus_req;
    logic            issue;
    req_id_t         issue_id;
    logic            i_done;
    logic            d_done;

    assign dbus_req = dbus_read | dbus_write;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        issue_id   = REQ_I;
        i_done     = 1'b0;
        d_done     = 1'b0;
        ibus_stall = ibus_read;
        ibus_data  = '0;
        ibus_error = 1'b0;
        dbus_stall = dbus_req;
        dbus_data  = '0;
        dbus_error = 1'b0;

        case (state)
            ARB_IDLE: begin
                // dbus wins unless ibus is waiting and has been passed over
                // STARVE_LIMIT times in a row.
                if (dbus_req && (!ibus_read || (starve_cnt < STARVE_MAX))) begin
                    state_nxt = ARB_GRANT_D;
                    issue     = 1'b1;
                    issue_id  = REQ_D;
                end else if (ibus_read) begin
                    state_nxt = ARB_GRANT_I;
                    issue     = 1'b1;
                    issue_id  = REQ_I;
                end
            end
            ARB_GRANT_I: begin
                if (!mem_stall) begin
                    state_nxt = ARB_IDLE;
                end
                // A requester that has dropped its request gets nothing back.
                i_done = !mem_stall && ibus_read;
            end
            ARB_GRANT_D: begin
                if (!mem_stall) begin
                    state_nxt = ARB_IDLE;
                end
                d_done = !mem_stall && dbus_req;
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase

        if (i_done) begin
            ibus_stall = 1'b0;
            ibus_data  = mem_rdata;
            ibus_error = mem_error;
        end
        if (d_done) begin
            dbus_stall = 1'b0;
            dbus_data  = mem_rdata;
            dbus_error = mem_error;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_address    <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_wdata      <= '0;
            mem_byteenable <= '0;
        end else if (issue) begin
            if (issue_id == REQ_D) begin
                mem_address    <= dbus_address;
                mem_read       <= !dbus_write;
                mem_write      <= dbus_write;
                mem_wdata      <= dbus_write ? dbus_wdata : '0;
                mem_byteenable <= dbus_write ? dbus_byteenable : '1;
            end else begin
                mem_address    <= ibus_address;
                mem_read       <= 1'b1;
                mem_write      <= 1'b0;
                mem_wdata      <= '0;
                mem_byteenable <= '1;
            end
        end else if ((state != ARB_IDLE) && !mem_stall) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (issue) begin
            if (issue_id == REQ_I) begin
                starve_cnt <= '0;
            end else if (ibus_read && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

`ifdef CPU_ARB_PERF_EN
    cpu_mem_bus_arb_perf #(
        .PERF_WIDTH (PERF_WIDTH)
    ) u_perf (
        .clock         (clock),
        .reset         (reset),
        .igrant        (issue && (issue_id == REQ_I)),
        .dgrant        (issue && (issue_id == REQ_D)),
        .conflict      (ibus_read && dbus_req),
        .perf_igrant   (perf_igrant),
        .perf_dgrant   (perf_dgrant),
        .perf_conflict (perf_conflict)
    );
`endif

endmodule

// File: tb/tb_cpu_mem_bus_arbiter.sv
module tb_cpu_mem_bus_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    logic        clock;
    logic        reset;
    logic [31:0] ibus_address;
    logic        ibus_read;
    logic [31:0] ibus_data;
    logic        ibus_stall;
    logic        ibus_error;
    logic [31:0] dbus_address;
    logic        dbus_read;
    logic        dbus_write;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_byteenable;
    logic [31:0] dbus_data;
    logic        dbus_stall;
    logic        dbus_error;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        mem_error;

    int checks   = 0;
    int failures = 0;
    txn_t exp_q[$];

    cpu_mem_bus_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ibus_address    (ibus_address),
        .ibus_read       (ibus_read),
        .ibus_data       (ibus_data),
        .ibus_stall      (ibus_stall),
        .ibus_error      (ibus_error),
        .dbus_address    (dbus_address),
        .dbus_read       (dbus_read),
        .dbus_write      (dbus_write),
        .dbus_wdata      (dbus_wdata),
        .dbus_byteenable (dbus_byteenable),
        .dbus_data       (dbus_data),
        .dbus_stall      (dbus_stall),
        .dbus_error      (dbus_error),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_wdata       (mem_wdata),
        .mem_byteenable  (mem_byteenable),
        .mem_rdata       (mem_rdata),
        .mem_stall       (mem_stall),
        .mem_error       (mem_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_txn(input logic [31:0] addr, input logic rd, input logic wr,
                            input logic [31:0] wdata, input logic [3:0] be);
        txn_t t;
        t.addr  = addr;
        t.rd    = rd;
        t.wr    = wr;
        t.wdata = wdata;
        t.be    = be;
        exp_q.push_back(t);
    endtask

    task automatic check_mem(input string tag);
        txn_t t;
        chk1({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            t = exp_q.pop_front();
            chk32({tag, "_addr"}, mem_address, t.addr);
            chk1({tag, "_rd"}, mem_read, t.rd);
            chk1({tag, "_wr"}, mem_write, t.wr);
            chk32({tag, "_wdata"}, mem_wdata, t.wdata);
            chk32({tag, "_be"}, 32'(mem_byteenable), 32'(t.be));
        end
    endtask

    initial begin
        reset           = 1'b0;
        ibus_address    = '0;
        ibus_read       = 1'b0;
        dbus_address    = '0;
        dbus_read       = 1'b0;
        dbus_write      = 1'b0;
        dbus_wdata      = '0;
        dbus_byteenable = '0;
        mem_rdata       = '0;
        mem_stall       = 1'b0;
        mem_error       = 1'b0;

        // reset state
        repeat (2) @(negedge clock);
        #1;
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk32("rst_mem_address", mem_address, 32'h0);
        chk32("rst_mem_be", 32'(mem_byteenable), 32'h0);
        chk1("rst_ibus_stall_idle", ibus_stall, 1'b0);
        chk32("rst_ibus_data", ibus_data, 32'h0);
        ibus_read = 1'b1;
        #1;
        chk1("rst_ibus_stall_req", ibus_stall, 1'b1);
        chk1("rst_ibus_error", ibus_error, 1'b0);
        ibus_read = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // ibus read alone, zero wait states
        ibus_address = 32'h0000_1000;
        ibus_read    = 1'b1;
        mem_rdata    = 32'h1111_1111;
        push_txn(32'h0000_1000, 1'b1, 1'b0, 32'h0, 4'hF);
        #1;
        chk1("t1_stall_idle", ibus_stall, 1'b1);
        chk1("t1_no_strobe_yet", mem_read, 1'b0);
        @(negedge clock);
        #1;
        check_mem("t1");
        chk1("t1_stall_done", ibus_stall, 1'b0);
        chk32("t1_data", ibus_data, 32'h1111_1111);
        chk1("t1_error", ibus_error, 1'b0);
        chk1("t1_dbus_stall", dbus_stall, 1'b0);
        ibus_read = 1'b0;
        @(negedge clock);
        #1;
        chk1("t1_strobe_cleared", mem_read, 1'b0);
        chk32("t1_data_idle", ibus_data, 32'h0);

        // simultaneous reads: dbus first
        @(negedge clock);
        ibus_address = 32'h0000_2000;
        ibus_read    = 1'b1;
        dbus_address = 32'h0000_3000;
        dbus_read    = 1'b1;
        mem_rdata    = 32'h2222_2222;
        push_txn(32'h0000_3000, 1'b1, 1'b0, 32'h0, 4'hF);
        push_txn(32'h0000_2000, 1'b1, 1'b0, 32'h0, 4'hF);
        #1;
        chk1("t2_istall_idle", ibus_stall, 1'b1);
        chk1("t2_dstall_idle", dbus_stall, 1'b1);
        @(negedge clock);
        #1;
        check_mem("t2_d");
        chk1("t2_d_dstall", dbus_stall, 1'b0);
        chk32("t2_d_data", dbus_data, 32'h2222_2222);
        chk1("t2_d_istall", ibus_stall, 1'b1);
        chk32("t2_d_idata", ibus_data, 32'h0);
        dbus_read = 1'b0;
        @(negedge clock);
        #1;
        chk1("t2_gap_istall", ibus_stall, 1'b1);
        mem_rdata = 32'h3333_3333;
        @(negedge clock);
        #1;
        check_mem("t2_i");
        chk1("t2_i_istall", ibus_stall, 1'b0);
        chk32("t2_i_data", ibus_data, 32'h3333_3333);
        ibus_read = 1'b0;
        @(negedge clock);

        // dbus write, also asserting read: write wins; one wait state
        dbus_address    = 32'h0000_4000;
        dbus_write      = 1'b1;
        dbus_read       = 1'b1;
        dbus_wdata      = 32'hDEAD_BEEF;
        dbus_byteenable = 4'b0011;
        mem_stall       = 1'b1;
        push_txn(32'h0000_4000, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        @(negedge clock);
        #1;
        check_mem("t3");
        chk1("t3_stall_wait", dbus_stall, 1'b1);
        @(negedge clock);
        mem_stall = 1'b0;
        #1;
        chk1("t3_hold_write", mem_write, 1'b1);
        chk32("t3_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk1("t3_stall_done", dbus_stall, 1'b0);
        chk1("t3_error", dbus_error, 1'b0);
        dbus_write = 1'b0;
        dbus_read  = 1'b0;
        @(negedge clock);
        #1;
        chk1("t3_write_cleared", mem_write, 1'b0);
        @(negedge clock);

        // starvation: dbus every cycle, ibus held
        ibus_address = 32'h0000_5000;
        ibus_read    = 1'b1;
        dbus_read    = 1'b1;
        mem_rdata    = 32'h4444_4444;
        for (int i = 0; i < 4; i++) begin
            push_txn(32'h0000_6000 + 32'(4 * i), 1'b1, 1'b0, 32'h0, 4'hF);
        end
        push_txn(32'h0000_5000, 1'b1, 1'b0, 32'h0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            dbus_address = 32'h0000_6000 + 32'(4 * i);
            #1;
            chk1("t4_istall_idle", ibus_stall, 1'b1);
            @(negedge clock);
            #1;
            check_mem("t4");
            if (i < 4) begin
                chk1("t4_d_dstall", dbus_stall, 1'b0);
                chk1("t4_d_istall", ibus_stall, 1'b1);
            end else begin
                chk1("t4_i_istall", ibus_stall, 1'b0);
                chk1("t4_i_dstall", dbus_stall, 1'b1);
            end
            @(negedge clock);
        end
        ibus_read = 1'b0;
        dbus_read = 1'b0;
        @(negedge clock);

        // memory error on the granted requester only
        ibus_address = 32'h0000_9000;
        ibus_read    = 1'b1;
        dbus_address = 32'h0000_A000;
        dbus_read    = 1'b1;
        mem_error    = 1'b1;
        push_txn(32'h0000_A000, 1'b1, 1'b0, 32'h0, 4'hF);
        push_txn(32'h0000_9000, 1'b1, 1'b0, 32'h0, 4'hF);
        @(negedge clock);
        #1;
        check_mem("t5_d");
        chk1("t5_derror", dbus_error, 1'b1);
        chk1("t5_ierror_loser", ibus_error, 1'b0);
        chk1("t5_dstall", dbus_stall, 1'b0);
        dbus_read = 1'b0;
        mem_error = 1'b0;
        @(negedge clock);
        #1;
        chk1("t5_derror_gone", dbus_error, 1'b0);
        @(negedge clock);
        #1;
        check_mem("t5_i");
        chk1("t5_istall", ibus_stall, 1'b0);
        chk1("t5_ierror", ibus_error, 1'b0);
        ibus_read = 1'b0;
        @(negedge clock);

        // reset in the middle of a stalled dbus grant
        dbus_address = 32'h0000_7000;
        dbus_read    = 1'b1;
        mem_stall    = 1'b1;
        push_txn(32'h0000_7000, 1'b1, 1'b0, 32'h0, 4'hF);
        @(negedge clock);
        #1;
        check_mem("t6_d");
        reset = 1'b0;
        #1;
        chk1("t6_rst_read", mem_read, 1'b0);
        chk32("t6_rst_addr", mem_address, 32'h0);
        chk32("t6_rst_be", 32'(mem_byteenable), 32'h0);
        chk1("t6_rst_dstall", dbus_stall, 1'b1);
        dbus_read    = 1'b0;
        ibus_address = 32'h0000_8000;
        ibus_read    = 1'b1;
        mem_stall    = 1'b0;
        mem_rdata    = 32'h5555_5555;
        @(negedge clock);
        #1;
        chk1("t6_held_read", mem_read, 1'b0);
        chk1("t6_held_istall", ibus_stall, 1'b1);
        reset = 1'b1;
        push_txn(32'h0000_8000, 1'b1, 1'b0, 32'h0, 4'hF);
        @(negedge clock);
        #1;
        check_mem("t6_i");
        chk1("t6_istall", ibus_stall, 1'b0);
        chk32("t6_idata", ibus_data, 32'h5555_5555);
        ibus_read = 1'b0;
        @(negedge clock);

        chk1("sb_drained", exp_q.size() == 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
